// File: rtl/proc_defs.sv
// proc_defs: shared processor opcodes, memory-stage state encodings and decode helpers.
package proc_defs;

    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } mau_state_t;

    function automatic logic is_load_op(input logic [31:0] ir);
        return ir[31:27] == OP_LW;
    endfunction

endpackage

// File: rtl/register_variable_falling.sv
// register_variable_falling: W-bit enabled register updating on the falling clock edge.
module register_variable_falling #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(negedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage between the XM and MW latches; stalls the pipeline
// while a load/store waits on a ready-handshake memory, with a timeout abort.
module mem_access_unit
    import proc_defs::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x_valid,
    input  logic [31:0]       ir_in,
    input  logic [31:0]       o_in,
    input  logic [31:0]       b_in,
    input  logic              mc_in,
    input  logic [4:0]        wc_in,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              mw_valid,
    output logic [31:0]       mw_o,
    output logic [31:0]       mw_d,
    output logic [31:0]       mw_ir,
    output logic [4:0]        mw_wc,
    output logic              mem_err
);

    mau_state_t        state, state_nx;
    logic [7:0]        cnt;
    logic              is_mem, cap, fin, tmo, idle_s, wait_s, done_s;
    logic [31:0]       fwd_b, d_nx;
    logic [ADDR_W-1:0] c_addr;
    logic              c_we;
    logic [31:0]       c_wdata, c_ir, c_o, c_d;
    logic [4:0]        c_wc;

    assign idle_s = state == ST_IDLE;
    assign wait_s = state == ST_WAIT;
    assign done_s = state == ST_DONE;
    assign is_mem = x_valid && (is_load_op(ir_in) || mc_in);
    // Store data may be produced by the instruction currently in writeback.
    assign fwd_b  = (wb_we && wb_rd != 5'd0 && wb_rd == ir_in[26:22]) ? wb_data : b_in;
    assign tmo    = cnt == 8'(TIMEOUT - 1);
    assign cap    = idle_s && is_mem;
    assign fin    = wait_s && (mem_ready || tmo);
    assign d_nx   = (mem_ready && !c_we) ? mem_rdata : 32'd0;

    always_comb begin
        state_nx = state;
        state_nx = cap ? ST_WAIT : fin ? ST_DONE : done_s ? ST_IDLE : state;
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 8'd0;
            mem_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cap ? 8'd0 : (wait_s && !mem_ready) ? cnt + 8'd1 : cnt;
            if (wait_s && !mem_ready && tmo)
                mem_err <= 1'b1;
        end
    end

    register_variable_falling #(.W(ADDR_W)) u_addr (
        .clk(clk), .reset(reset), .en(cap), .d(o_in[ADDR_W-1:0]), .q(c_addr));
    register_variable_falling #(.W(1)) u_we (
        .clk(clk), .reset(reset), .en(cap), .d(mc_in), .q(c_we));
    register_variable_falling #(.W(32)) u_wdata (
        .clk(clk), .reset(reset), .en(cap), .d(fwd_b), .q(c_wdata));
    register_variable_falling #(.W(32)) u_ir (
        .clk(clk), .reset(reset), .en(cap), .d(ir_in), .q(c_ir));
    register_variable_falling #(.W(32)) u_o (
        .clk(clk), .reset(reset), .en(cap), .d(o_in), .q(c_o));
    register_variable_falling #(.W(5)) u_wc (
        .clk(clk), .reset(reset), .en(cap), .d(wc_in), .q(c_wc));
    // Timeouts and stores deliver zero as their MW data.
    register_variable_falling #(.W(32)) u_d (
        .clk(clk), .reset(reset), .en(fin), .d(d_nx), .q(c_d));

    always_comb begin
        mem_req   = !reset && wait_s;
        mem_we    = !reset && wait_s && c_we;
        mem_addr  = c_addr;
        mem_wdata = c_wdata;
        stall     = !reset && (wait_s || cap);
        mw_valid  = !reset && (done_s || (idle_s && x_valid && !is_mem));
        mw_o      = idle_s ? o_in : c_o;
        mw_ir     = idle_s ? ir_in : c_ir;
        mw_wc     = idle_s ? wc_in : c_wc;
        mw_d      = done_s ? c_d : 32'd0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a
// transaction-level expectation model (latency, forwarding, timeout, reset).
module tb_mem_access_unit;
    import proc_defs::*;

    localparam int AW = 12;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset, x_valid, mc_in, wb_we, mem_ready;
    logic [31:0]   ir_in, o_in, b_in, wb_data, mem_rdata;
    logic [4:0]    wc_in, wb_rd;
    logic          mem_req, mem_we, stall, mw_valid, mem_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mw_o, mw_d, mw_ir;
    logic [4:0]    mw_wc;

    int   tests = 0;
    int   fails = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .x_valid(x_valid), .ir_in(ir_in), .o_in(o_in),
        .b_in(b_in), .mc_in(mc_in), .wc_in(wc_in), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .mw_valid(mw_valid), .mw_o(mw_o), .mw_d(mw_d), .mw_ir(mw_ir),
        .mw_wc(mw_wc), .mem_err(mem_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu_op(input logic xv, input logic [31:0] ir, input logic [31:0] o,
                          input logic [4:0] wc);
        @(negedge clk); #1;
        x_valid = xv; ir_in = ir; o_in = o; wc_in = wc; mc_in = 1'b0;
        b_in = $urandom; mem_ready = 1'b0;
        @(posedge clk);
        chk("alu_stall", stall, 0);
        chk("alu_mw_valid", mw_valid, xv);
        chk("alu_mw_o", mw_o, o);
        chk("alu_mw_ir", mw_ir, ir);
        chk("alu_mw_wc", mw_wc, wc);
        chk("alu_mw_d", mw_d, 0);
        chk("alu_mem_req", mem_req, 0);
        chk("alu_mem_err", mem_err, exp_err);
    endtask

    // lat = WAIT cycle (1-based) in which memory answers; lat > TO never answers in time.
    task automatic mem_op(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] b,
                          input logic mc, input logic [4:0] wc, input logic wwe,
                          input logic [4:0] wrd, input logic [31:0] wdat, input int lat,
                          input logic [31:0] rdata);
        logic [31:0] exp_wd, exp_d;
        int waits;
        exp_wd = (wwe && wrd != 5'd0 && wrd == ir[26:22]) ? wdat : b;
        waits  = (lat <= TO) ? lat : TO;
        exp_d  = (lat <= TO && !mc) ? rdata : 32'd0;
        @(negedge clk); #1;
        x_valid = 1'b1; ir_in = ir; o_in = o; b_in = b; mc_in = mc; wc_in = wc;
        wb_we = wwe; wb_rd = wrd; wb_data = wdat; mem_ready = 1'b0;
        @(posedge clk);
        chk("det_stall", stall, 1);
        chk("det_mw_valid", mw_valid, 0);
        chk("det_mem_req", mem_req, 0);
        @(negedge clk); #1;
        wb_we = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
        o_in = $urandom; b_in = $urandom;
        for (int i = 1; i <= waits; i++) begin
            mem_ready = (i == lat);
            mem_rdata = (i == lat) ? rdata : $urandom;
            @(posedge clk);
            chk("wait_mem_req", mem_req, 1);
            chk("wait_mem_we", mem_we, mc);
            chk("wait_mem_addr", mem_addr, o[AW-1:0]);
            chk("wait_mem_wdata", mem_wdata, exp_wd);
            chk("wait_stall", stall, 1);
            chk("wait_mw_valid", mw_valid, 0);
            @(negedge clk); #1;
        end
        if (lat > TO) exp_err = 1'b1;
        mem_ready = 1'b0; mem_rdata = $urandom;
        @(posedge clk);
        chk("done_stall", stall, 0);
        chk("done_mw_valid", mw_valid, 1);
        chk("done_mw_d", mw_d, exp_d);
        chk("done_mw_o", mw_o, o);
        chk("done_mw_ir", mw_ir, ir);
        chk("done_mw_wc", mw_wc, wc);
        chk("done_mem_req", mem_req, 0);
        chk("done_mem_we", mem_we, 0);
        chk("done_mem_err", mem_err, exp_err);
    endtask

    function automatic logic [31:0] non_mem_ir();
        logic [31:0] r;
        r = $urandom;
        if (r[31:27] == OP_LW) r[31] = 1'b1;
        return r;
    endfunction

    initial begin
        reset = 1'b1; x_valid = 1'b1; ir_in = 32'h0; o_in = 32'h55; b_in = 32'h0;
        mc_in = 1'b0; wc_in = 5'd1; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        mem_rdata = 32'h0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_mw_valid", mw_valid, 0);
        @(negedge clk); #1;
        reset = 1'b0; x_valid = 1'b0;
        @(posedge clk);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_mw_d", mw_d, 0);
        chk("rst_mem_we", mem_we, 0);

        alu_op(1'b1, {5'b00000, 27'h0421}, 32'h1234, 5'd4);
        alu_op(1'b0, {OP_LW, 27'h0}, 32'h99, 5'd2);
        mem_op({OP_LW, 5'd1, 22'h0}, 32'h10, 32'h0, 1'b0, 5'd7, 1'b0, 5'd0, 32'h0, 1, 32'hDEADBEEF);
        mem_op({OP_SW, 5'd3, 22'h0}, 32'h24, 32'd5, 1'b1, 5'd0, 1'b1, 5'd3, 32'd9, 3, 32'h0);
        mem_op({OP_SW, 5'd0, 22'h0}, 32'h38, 32'd6, 1'b1, 5'd0, 1'b1, 5'd0, 32'd9, 2, 32'h0);
        mem_op({OP_LW, 5'd2, 22'h7}, 32'hABC, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 2, 32'h0BADF00D);
        mem_op({OP_LW, 5'd2, 22'h7}, 32'h7FF, 32'h0, 1'b0, 5'd9, 1'b0, 5'd0, 32'h0, TO, 32'h13572468);
        mem_op({OP_LW, 5'd5, 22'h1}, 32'h44, 32'h0, 1'b0, 5'd11, 1'b0, 5'd0, 32'h0, TO + 1, 32'h11111111);
        alu_op(1'b1, 32'h0, 32'h77, 5'd3);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                alu_op(1'($urandom), non_mem_ir(), $urandom, 5'($urandom));
            end else begin
                logic        st;
                logic [31:0] ir;
                logic [4:0]  rs;
                st = 1'($urandom);
                rs = 5'($urandom_range(0, 3));
                ir = {st ? OP_SW : OP_LW, rs, 22'($urandom)};
                mem_op(ir, $urandom, $urandom, st, 5'($urandom), 1'($urandom),
                       5'($urandom_range(0, 3)), $urandom, $urandom_range(1, TO + 1), $urandom);
            end
        end

        @(negedge clk); #1;
        x_valid = 1'b1; ir_in = {OP_LW, 27'h0}; o_in = 32'h20; mc_in = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        chk("rw_det_stall", stall, 1);
        @(negedge clk); #1;
        @(posedge clk);
        chk("rw_wait_req", mem_req, 1);
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        chk("rw_in_rst_req", mem_req, 0);
        chk("rw_in_rst_stall", stall, 0);
        chk("rw_in_rst_valid", mw_valid, 0);
        @(negedge clk); #1;
        reset = 1'b0; x_valid = 1'b0;
        exp_err = 1'b0;
        @(posedge clk);
        chk("rw_after_req", mem_req, 0);
        chk("rw_after_stall", stall, 0);
        chk("rw_after_err", mem_err, 0);
        chk("rw_after_valid", mw_valid, 0);
        chk("rw_after_mw_d", mw_d, 0);
        alu_op(1'b1, 32'h0, 32'hCAFE, 5'd6);
        mem_op({OP_LW, 5'd1, 22'h0}, 32'h30, 32'h0, 1'b0, 5'd8, 1'b0, 5'd0, 32'h0, 1, 32'h600DCAFE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset, with all state updating on the falling edge of clk, matching the pipeline latches.
REQ-002 Parameters, one per line:
- ADDR_W, 12, data-memory word-address width.
- TIMEOUT, 255, maximum WAIT cycles before abort (1..255).
REQ-003 Ports, one per line:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- x_valid  in  1  XM latch holds a real instruction
- ir_in  in  32  instruction from XM latch
- o_in  in  32  ALU result / address from XM latch
- b_in  in  32  store data from XM latch
- mc_in  in  1  store control from XM latch
- wc_in  in  5  destination register from XM latch
- wb_we  in  1  writeback stage writes the register file
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback value
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data
- mem_ready  in  1  memory completes the request this cycle
- stall  out  1  freeze PC/FD/DX/XM latches
- mw_valid  out  1  MW latch input valid
- mw_o  out  32  ALU result to MW
- mw_d  out  32  load data to MW
- mw_ir  out  32  instruction to MW
- mw_wc  out  5  destination to MW
- mem_err  out  1  sticky timeout flag

Function
REQ-004 Memory op: is_load = (ir_in[31:27]==5'b01000); is_store = mc_in; only when x_valid=1.
REQ-005 States: IDLE, WAIT, DONE (2-bit).
REQ-006 IDLE, non-memory op: stall=0, mw_valid=x_valid, mw_ir/mw_o/mw_wc pass through combinationally, mw_d=0, state stays IDLE.
REQ-007 IDLE, memory op: stall=1, mw_valid=0; at the edge capture addr=o_in[ADDR_W-1:0], we=is_store, wdata=fwd(b_in), ir, o, wc; zero the timeout counter; go to WAIT.
REQ-008 Forwarding: fwd(b_in)=wb_data if wb_we=1, wb_rd!=0 and wb_rd==ir_in[26:22]; otherwise b_in.
REQ-009 WAIT: mem_req=1; mem_we, mem_addr and mem_wdata come from the captured registers and are held stable; stall=1; mw_valid=0.
REQ-010 WAIT, mem_ready=1: capture mem_rdata, or 0 for a store; go to DONE.
REQ-011 WAIT, mem_ready=0: increment the counter; when it equals TIMEOUT-1, set mem_err, capture 0, and go to DONE.
REQ-012 Simultaneous mem_ready and timeout: ready wins and mem_err is unchanged.
REQ-013 DONE: stall=0; mw_valid=1; mw_ir/mw_o/mw_wc come from the captured registers; mw_d holds the captured data; mem_req=0; go to IDLE unconditionally, with no re-trigger on the still-present instruction.
REQ-014 Latency: a memory op stalls for at least 2 cycles (IDLE detection + WAIT), plus 1 per extra wait cycle.
REQ-015 Outside WAIT: mem_req=0, mem_we=0.
REQ-016 mem_err is sticky until reset.
REQ-017 A load with wc_in=0 still performs the read; the destination passes through unchanged.

Reset
REQ-018 Reset SHALL force the following on the next falling edge, including mid-WAIT with the request abandoned:
- state=IDLE;
- counter=0;
- mem_err=0;
- all captured registers=0.
REQ-019 While reset is asserted: mem_req=0, stall=0, mw_valid=0.

Structure
REQ-020 Opcode constants (LW 5'b01000, SW 5'b00111) and state encodings SHALL live in the shared processor definitions package, proc_defs.
REQ-021 Captured registers SHALL instantiate register_variable_falling; the FSM and counter are local.

Verification
REQ-022 ALU op add, x_valid=1, o_in=0x1234 -> same-cycle mw_o=0x1234, mw_valid=1, stall=0.
REQ-023 Load, o_in=0x00000010, mem_ready high in the first WAIT cycle with rdata=0xDEADBEEF:
- mem_addr=0x010;
- stall for 2 cycles;
- DONE mw_d=0xDEADBEEF.
REQ-024 Store, b_in=5, with wb_we=1, wb_rd=ir_in[26:22]=3, wb_data=9 in the IDLE cycle -> mem_wdata=9 and mem_we=1 throughout WAIT.
REQ-025 Load, mem_ready held low with TIMEOUT=4 -> DONE after 4 WAIT cycles, mw_d=0, mem_err=1 and remaining 1 afterwards.
REQ-026 Reset asserted in the second WAIT cycle -> next cycle state IDLE, mem_req=0, stall=0, mem_err=0.
